// File: rtl/mips8_pad_loader.sv
// rtl/mips8_pad_loader.sv - pad byte-stream boot loader for the MIPS8 core
// Synchronises the pad bus, writes strobed bytes into program memory, gates core reset.
module mips8_pad_loader #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int LOAD_BYTES  = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [DATA_W-1:0] pad_data_i,
   input  logic              pad_strobe_i,
   input  logic              pad_load_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              cpu_rst_o,
   output logic              load_done_o,
   output logic [ADDR_W:0]   byte_cnt_o
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(LOAD_BYTES - 1);

   logic [1:0]             state;
   logic [SYNC_STAGES-1:0] stb_sync;
   logic [SYNC_STAGES-1:0] load_sync;
   logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
   logic                   stb_s_q;
   logic                   load_s_q;
   logic                   stb_s;
   logic                   load_s;
   logic [DATA_W-1:0]      data_s;
   logic                   stb_rise;
   logic                   load_rise;

   assign stb_s     = stb_sync[SYNC_STAGES-1];
   assign load_s    = load_sync[SYNC_STAGES-1];
   assign data_s    = data_sync[SYNC_STAGES-1];
   assign stb_rise  = stb_s & ~stb_s_q;
   assign load_rise = load_s & ~load_s_q;

   // Data takes the same number of stages as the strobe so both arrive aligned.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         stb_sync  <= '0;
         load_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      end else begin
         stb_sync     <= {stb_sync[SYNC_STAGES-2:0], pad_strobe_i};
         load_sync    <= {load_sync[SYNC_STAGES-2:0], pad_load_i};
         data_sync[0] <= pad_data_i;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= ST_BOOT;
         stb_s_q     <= 1'b0;
         load_s_q    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         cpu_rst_o   <= 1'b1;
         load_done_o <= 1'b0;
         byte_cnt_o  <= '0;
      end else begin
         stb_s_q  <= stb_s;
         load_s_q <= load_s;
         mem_we_o <= 1'b0;
         case (state)
            ST_BOOT: begin
               if (load_s) begin
                  state <= ST_LOAD;
               end else begin
                  state       <= ST_RUN;
                  cpu_rst_o   <= 1'b0;
                  load_done_o <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (mem_we_o) begin
                  // End of a write cycle: advance, and leave once the image is full
                  // or the host dropped load mode while this byte was in flight.
                  byte_cnt_o <= byte_cnt_o + 1'b1;
                  if (byte_cnt_o != LAST_CNT) mem_addr_o <= mem_addr_o + 1'b1;
                  if (byte_cnt_o == LAST_CNT || !load_s) begin
                     state       <= ST_RUN;
                     cpu_rst_o   <= 1'b0;
                     load_done_o <= 1'b1;
                  end
               end else if (stb_rise) begin
                  mem_we_o    <= 1'b1;
                  mem_wdata_o <= data_s;
               end else if (!load_s) begin
                  state       <= ST_RUN;
                  cpu_rst_o   <= 1'b0;
                  load_done_o <= 1'b1;
               end
            end
            ST_RUN: begin
               if (load_rise) begin
                  state       <= ST_LOAD;
                  cpu_rst_o   <= 1'b1;
                  load_done_o <= 1'b0;
                  mem_addr_o  <= '0;
                  byte_cnt_o  <= '0;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_mips8_pad_loader.sv
// tb/tb_mips8_pad_loader.sv - scoreboard bench for mips8_pad_loader
// Stimulus pushes expected writes; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mips8_pad_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pad_data = 8'h00;
   logic       pad_strobe = 1'b0;
   logic       pad_load = 1'b0;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_rst;
   logic       load_done;
   logic [8:0] byte_cnt;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   mips8_pad_loader #(.DATA_W(8), .ADDR_W(8), .LOAD_BYTES(64), .SYNC_STAGES(2)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .pad_data_i(pad_data), .pad_strobe_i(pad_strobe),
      .pad_load_i(pad_load), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .cpu_rst_o(cpu_rst), .load_done_o(load_done),
      .byte_cnt_o(byte_cnt)
   );

   always @(negedge clk) begin
      if (mem_we) begin
         logic [15:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        mem_addr, mem_wdata, e[15:8], e[7:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
      chk({tag, "_done"}, 32'(load_done), 0);
      chk({tag, "_cnt"}, 32'(byte_cnt), 0);
   endtask

   task automatic wait_done(input logic want, input string name);
      int n = 0;
      while (load_done !== want && n < 10) begin @(negedge clk); n++; end
      chk(name, 32'(load_done), 32'(want));
   endtask

   task automatic wait_cpu_rst(input logic want, input int bound, input string name);
      int n = 0;
      while (cpu_rst !== want && n < bound) begin @(negedge clk); n++; end
      chk(name, 32'(cpu_rst), 32'(want));
   endtask

   task automatic strobe_rise(input logic [7:0] d, input logic [7:0] a, input bit expect_write);
      @(negedge clk);
      pad_data = d;
      @(negedge clk);
      pad_strobe = 1'b1;
      if (expect_write) exp_q.push_back({a, d});
   endtask

   task automatic strobe_fall();
      repeat (4) @(negedge clk);
      pad_strobe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] a);
      strobe_rise(d, a, 1'b1);
      strobe_fall();
   endtask

   task automatic enter_load(input string name);
      @(negedge clk);
      pad_load = 1'b0;
      repeat (4) @(negedge clk);
      pad_load = 1'b1;
      wait_cpu_rst(1'b1, 6, name);
      chk({name, "_cnt"}, 32'(byte_cnt), 0);
   endtask

   initial begin
      // 1: reset, no load request -> RUN
      repeat (2) @(negedge clk);
      chk_reset_vals("rst1");
      rst = 1'b0;
      wait_done(1'b1, "t1_done");
      chk("t1_cpu_rst", 32'(cpu_rst), 0);
      repeat (5) @(negedge clk);

      // 2: full 64-byte image, data = addr
      pad_load = 1'b1;
      wait_cpu_rst(1'b1, 6, "t2_enter");
      chk("t2_done_low", 32'(load_done), 0);
      for (int i = 0; i < 63; i++) send(8'(i), 8'(i));
      strobe_rise(8'h3F, 8'd63, 1'b1);
      begin
         int n = 0;
         while (mem_we !== 1'b1 && n < 8) begin @(negedge clk); n++; end
         chk("t2_last_write_seen", 32'(mem_we), 1);
      end
      chk("t2_cpu_rst_during_last", 32'(cpu_rst), 1);
      @(negedge clk);
      chk("t2_cpu_rst_after", 32'(cpu_rst), 0);
      chk("t2_done_after", 32'(load_done), 1);
      chk("t2_cnt", 32'(byte_cnt), 64);
      strobe_fall();

      // 3: partial load of 5 bytes
      enter_load("t3_enter");
      for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 8'(i));
      pad_load = 1'b0;
      wait_done(1'b1, "t3_done");
      chk("t3_cnt", 32'(byte_cnt), 5);
      chk("t3_cpu_rst", 32'(cpu_rst), 0);

      // 4: strobe held high, then strobe rise coincident with load fall
      enter_load("t4_enter");
      strobe_rise(8'h5A, 8'd0, 1'b1);
      repeat (20) @(negedge clk);
      pad_strobe = 1'b0;
      repeat (3) @(negedge clk);
      pad_data = 8'hC3;
      @(negedge clk);
      pad_strobe = 1'b1;
      pad_load = 1'b0;
      exp_q.push_back({8'd1, 8'hC3});
      wait_done(1'b1, "t4_done");
      chk("t4_cnt", 32'(byte_cnt), 2);
      strobe_fall();

      // 5: reset mid-load aborts the in-flight byte; next load restarts at 0
      enter_load("t5_enter");
      for (int i = 0; i <= 10; i++) send(8'h10 + 8'(i), 8'(i));
      chk("t5_cnt_before", 32'(byte_cnt), 11);
      strobe_rise(8'hEE, 8'd11, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals("rst5");
      repeat (2) @(negedge clk);
      pad_strobe = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5_reload_cpu_rst", 32'(cpu_rst), 1);
      chk("t5_reload_cnt", 32'(byte_cnt), 0);
      send(8'h66, 8'd0);
      send(8'h67, 8'd1);
      chk("t5_cnt_after", 32'(byte_cnt), 2);

      // 6: strobes ignored in RUN; load re-assert restarts at 0
      pad_load = 1'b0;
      wait_done(1'b1, "t6_run");
      for (int i = 0; i < 3; i++) begin strobe_rise(8'hF0, 8'd0, 1'b0); strobe_fall(); end
      chk("t6_cnt_kept", 32'(byte_cnt), 2);
      @(negedge clk);
      pad_load = 1'b1;
      wait_cpu_rst(1'b1, 3, "t6_cpu_rst_latency");
      send(8'h77, 8'd0);
      chk("t6_cnt", 32'(byte_cnt), 1);

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
